// File: rtl/exec_pkg.sv
// Shared constants and types for the execute-stage sequencer and its decoder.
// Optional build macro: EXEC_BRANCH_CMP_EN (adds beq/bne compare opcodes).
package exec_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned ALUC_W  = 4;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned IMM_W   = 16;

   // ALU operation codes, matching the downstream ALU encoding
   localparam logic [ALUC_W-1:0] ALUC_ADDU = 4'b0000;
   localparam logic [ALUC_W-1:0] ALUC_SUBU = 4'b0001;
   localparam logic [ALUC_W-1:0] ALUC_ADD  = 4'b0010;
   localparam logic [ALUC_W-1:0] ALUC_SUB  = 4'b0011;
   localparam logic [ALUC_W-1:0] ALUC_AND  = 4'b0100;
   localparam logic [ALUC_W-1:0] ALUC_OR   = 4'b0101;
   localparam logic [ALUC_W-1:0] ALUC_XOR  = 4'b0110;
   localparam logic [ALUC_W-1:0] ALUC_NOR  = 4'b0111;
   localparam logic [ALUC_W-1:0] ALUC_LUI  = 4'b1000;
   localparam logic [ALUC_W-1:0] ALUC_SLTU = 4'b1010;
   localparam logic [ALUC_W-1:0] ALUC_SLT  = 4'b1011;
   localparam logic [ALUC_W-1:0] ALUC_SRA  = 4'b1100;
   localparam logic [ALUC_W-1:0] ALUC_SRL  = 4'b1101;
   localparam logic [ALUC_W-1:0] ALUC_SLL  = 4'b1110;

   // Opcodes
   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
   localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
   localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
   localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;

   // R-type funct codes
   localparam logic [OP_W-1:0] FN_SLL  = 6'h00;
   localparam logic [OP_W-1:0] FN_SRL  = 6'h02;
   localparam logic [OP_W-1:0] FN_SRA  = 6'h03;
   localparam logic [OP_W-1:0] FN_SLLV = 6'h04;
   localparam logic [OP_W-1:0] FN_SRLV = 6'h06;
   localparam logic [OP_W-1:0] FN_SRAV = 6'h07;
   localparam logic [OP_W-1:0] FN_ADD  = 6'h20;
   localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
   localparam logic [OP_W-1:0] FN_SUB  = 6'h22;
   localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
   localparam logic [OP_W-1:0] FN_AND  = 6'h24;
   localparam logic [OP_W-1:0] FN_OR   = 6'h25;
   localparam logic [OP_W-1:0] FN_XOR  = 6'h26;
   localparam logic [OP_W-1:0] FN_NOR  = 6'h27;
   localparam logic [OP_W-1:0] FN_SLT  = 6'h2A;
   localparam logic [OP_W-1:0] FN_SLTU = 6'h2B;

   typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_EXEC, ST_DONE} state_t;

   // Sign-extend a 16-bit immediate to the datapath width
   function automatic logic [DATA_W-1:0] sext16(input logic [IMM_W-1:0] imm);
      return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of an instruction into ALU control and operands.
// Optional build macro: EXEC_BRANCH_CMP_EN (decodes beq/bne).
module alu_op_decode
   import exec_pkg::*;
(
   input  logic [OP_W-1:0]    opcode_i,
   input  logic [OP_W-1:0]    funct_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   input  logic [IMM_W-1:0]   imm16_i,
   input  logic [DATA_W-1:0]  rs_i,
   input  logic [DATA_W-1:0]  rt_i,
   output logic [ALUC_W-1:0]  aluc_o,
   output logic [DATA_W-1:0]  a_o,
   output logic [DATA_W-1:0]  b_o,
`ifdef EXEC_BRANCH_CMP_EN
   output logic               branch_o,
   output logic               bne_o,
`endif
   output logic               is_addsub_o,
   output logic               illegal_o
);

   logic [ALUC_W-1:0] aluc;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              ill;

   // Opcode/funct table; undecodable encodings force a benign addu of zeros
   always_comb begin
      aluc        = ALUC_ADDU;
      a           = rs_i;
      b           = rt_i;
      ill         = 1'b0;
      is_addsub_o = 1'b0;
`ifdef EXEC_BRANCH_CMP_EN
      branch_o    = 1'b0;
      bne_o       = 1'b0;
`endif
      case (opcode_i)
         OP_RTYPE: begin
            case (funct_i)
               FN_ADD:  begin aluc = ALUC_ADD; is_addsub_o = 1'b1; end
               FN_ADDU: aluc = ALUC_ADDU;
               FN_SUB:  begin aluc = ALUC_SUB; is_addsub_o = 1'b1; end
               FN_SUBU: aluc = ALUC_SUBU;
               FN_AND:  aluc = ALUC_AND;
               FN_OR:   aluc = ALUC_OR;
               FN_XOR:  aluc = ALUC_XOR;
               FN_NOR:  aluc = ALUC_NOR;
               FN_SLT:  aluc = ALUC_SLT;
               FN_SLTU: aluc = ALUC_SLTU;
               FN_SLL:  begin aluc = ALUC_SLL; a = DATA_W'(shamt_i); end
               FN_SRL:  begin aluc = ALUC_SRL; a = DATA_W'(shamt_i); end
               FN_SRA:  begin aluc = ALUC_SRA; a = DATA_W'(shamt_i); end
               FN_SLLV: begin aluc = ALUC_SLL; a = DATA_W'(rs_i[SHAMT_W-1:0]); end
               FN_SRLV: begin aluc = ALUC_SRL; a = DATA_W'(rs_i[SHAMT_W-1:0]); end
               FN_SRAV: begin aluc = ALUC_SRA; a = DATA_W'(rs_i[SHAMT_W-1:0]); end
               default: ill = 1'b1;
            endcase
         end
         OP_ADDI:  begin aluc = ALUC_ADD;  b = sext16(imm16_i); is_addsub_o = 1'b1; end
         OP_ADDIU: begin aluc = ALUC_ADDU; b = sext16(imm16_i); end
         OP_SLTI:  begin aluc = ALUC_SLT;  b = sext16(imm16_i); end
         OP_SLTIU: begin aluc = ALUC_SLTU; b = sext16(imm16_i); end
         OP_ANDI:  begin aluc = ALUC_AND;  b = DATA_W'(imm16_i); end
         OP_ORI:   begin aluc = ALUC_OR;   b = DATA_W'(imm16_i); end
         OP_XORI:  begin aluc = ALUC_XOR;  b = DATA_W'(imm16_i); end
         OP_LUI:   begin aluc = ALUC_LUI;  b = DATA_W'(imm16_i); end
`ifdef EXEC_BRANCH_CMP_EN
         OP_BEQ:   begin aluc = ALUC_SUBU; branch_o = 1'b1; end
         OP_BNE:   begin aluc = ALUC_SUBU; branch_o = 1'b1; bne_o = 1'b1; end
`endif
         default:  ill = 1'b1;
      endcase
      if (ill) begin
         aluc        = ALUC_ADDU;
         a           = '0;
         b           = '0;
         is_addsub_o = 1'b0;
      end
   end

   assign aluc_o    = aluc;
   assign a_o       = a;
   assign b_o       = b;
   assign illegal_o = ill;

endmodule

// File: rtl/alu_exec_seq.sv
// Multi-cycle execute sequencer: latch, decode, drive ALU, capture ALUOut.
// Optional build macro: EXEC_BRANCH_CMP_EN (beq/bne with branch_taken output).
module alu_exec_seq
   import exec_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [OP_W-1:0]     opcode,
   input  logic [OP_W-1:0]     funct,
   input  logic [SHAMT_W-1:0]  shamt,
   input  logic [IMM_W-1:0]    imm16,
   input  logic [DATA_W-1:0]   rs_val,
   input  logic [DATA_W-1:0]   rt_val,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   output logic [ALUC_W-1:0]   aluc,
   input  logic [DATA_W-1:0]   alu_r,
   input  logic                alu_zero,
   input  logic                alu_overflow,
   output logic                busy,
   output logic                done,
   output logic [DATA_W-1:0]   result,
   output logic                zero_q,
   output logic                wb_en,
   output logic                ovf_trap,
`ifdef EXEC_BRANCH_CMP_EN
   output logic                branch_taken,
`endif
   output logic                illegal
);

   state_t              state_q, state_d;
   logic [OP_W-1:0]     opcode_q, funct_q;
   logic [SHAMT_W-1:0]  shamt_q;
   logic [IMM_W-1:0]    imm16_q;
   logic [DATA_W-1:0]   rs_q, rt_q;
   logic [ALUC_W-1:0]   aluc_q;
   logic [DATA_W-1:0]   alu_a_q, alu_b_q, result_q;
   logic                is_addsub_q, illegal_dec_q;
   logic                busy_q, done_q, zero_flag_q, wb_en_q, ovf_trap_q, illegal_q;

   logic [ALUC_W-1:0]   dec_aluc;
   logic [DATA_W-1:0]   dec_a, dec_b;
   logic                dec_is_addsub, dec_illegal;
   logic                accept_c, ovf_c;

`ifdef EXEC_BRANCH_CMP_EN
   logic                dec_branch, dec_bne;
   logic                branch_q, bne_q, branch_taken_q;
`endif

   alu_op_decode u_decode (
      .opcode_i    (opcode_q),
      .funct_i     (funct_q),
      .shamt_i     (shamt_q),
      .imm16_i     (imm16_q),
      .rs_i        (rs_q),
      .rt_i        (rt_q),
      .aluc_o      (dec_aluc),
      .a_o         (dec_a),
      .b_o         (dec_b),
`ifdef EXEC_BRANCH_CMP_EN
      .branch_o    (dec_branch),
      .bne_o       (dec_bne),
`endif
      .is_addsub_o (dec_is_addsub),
      .illegal_o   (dec_illegal)
   );

   // Start is only honoured when no operation is in flight
   assign accept_c = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   // Overflow is meaningless (possibly Z/X) outside add/sub, so gate it off
   assign ovf_c    = is_addsub_q & alu_overflow;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_DECODE;
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC:   state_d = ST_DONE;
         ST_DONE:   state_d = start ? ST_DECODE : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // State, operand latch, decode register and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         opcode_q      <= '0;
         funct_q       <= '0;
         shamt_q       <= '0;
         imm16_q       <= '0;
         rs_q          <= '0;
         rt_q          <= '0;
         aluc_q        <= '0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         is_addsub_q   <= 1'b0;
         illegal_dec_q <= 1'b0;
         result_q      <= '0;
         zero_flag_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         wb_en_q       <= 1'b0;
         ovf_trap_q    <= 1'b0;
         illegal_q     <= 1'b0;
`ifdef EXEC_BRANCH_CMP_EN
         branch_q       <= 1'b0;
         bne_q          <= 1'b0;
         branch_taken_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         busy_q     <= (state_d == ST_DECODE) || (state_d == ST_EXEC);
         done_q     <= 1'b0;
         wb_en_q    <= 1'b0;
         ovf_trap_q <= 1'b0;
         illegal_q  <= 1'b0;
`ifdef EXEC_BRANCH_CMP_EN
         branch_taken_q <= 1'b0;
`endif
         if (accept_c) begin
            opcode_q <= opcode;
            funct_q  <= funct;
            shamt_q  <= shamt;
            imm16_q  <= imm16;
            rs_q     <= rs_val;
            rt_q     <= rt_val;
         end
         if (state_q == ST_DECODE) begin
            aluc_q        <= dec_aluc;
            alu_a_q       <= dec_a;
            alu_b_q       <= dec_b;
            is_addsub_q   <= dec_is_addsub;
            illegal_dec_q <= dec_illegal;
`ifdef EXEC_BRANCH_CMP_EN
            branch_q      <= dec_branch;
            bne_q         <= dec_bne;
`endif
         end
         if (state_q == ST_EXEC) begin
            done_q <= 1'b1;
            if (illegal_dec_q) begin
               illegal_q <= 1'b1;
`ifdef EXEC_BRANCH_CMP_EN
            end else if (branch_q) begin
               branch_taken_q <= bne_q ? ~alu_zero : alu_zero;
`endif
            end else if (ovf_c) begin
               ovf_trap_q <= 1'b1;
            end else begin
               wb_en_q     <= 1'b1;
               result_q    <= alu_r;
               zero_flag_q <= alu_zero;
            end
         end
      end
   end

   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign aluc     = aluc_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign zero_q   = zero_flag_q;
   assign wb_en    = wb_en_q;
   assign ovf_trap = ovf_trap_q;
   assign illegal  = illegal_q;
`ifdef EXEC_BRANCH_CMP_EN
   assign branch_taken = branch_taken_q;
`endif

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: directed cases plus randomized traffic
// against an instruction-level reference model.
module tb_alu_exec_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [5:0]  opcode, funct;
   logic [4:0]  shamt;
   logic [15:0] imm16;
   logic [31:0] rs_val, rt_val;
   logic [31:0] alu_a, alu_b, alu_r, result;
   logic [3:0]  aluc;
   logic        alu_zero, alu_overflow;
   logic        busy, done, zero_q, wb_en, ovf_trap, illegal;
`ifdef EXEC_BRANCH_CMP_EN
   logic        branch_taken;
`endif

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   alu_exec_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .opcode(opcode), .funct(funct), .shamt(shamt), .imm16(imm16),
      .rs_val(rs_val), .rt_val(rt_val),
      .alu_a(alu_a), .alu_b(alu_b), .aluc(aluc),
      .alu_r(alu_r), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .busy(busy), .done(done), .result(result), .zero_q(zero_q),
      .wb_en(wb_en), .ovf_trap(ovf_trap),
`ifdef EXEC_BRANCH_CMP_EN
      .branch_taken(branch_taken),
`endif
      .illegal(illegal)
   );

   // Behavioural ALU; overflow is driven as junk (1) for non add/sub ops
   always_comb begin
      alu_overflow = 1'b1;
      case (aluc)
         4'b0000, 4'b0010: alu_r = alu_a + alu_b;
         4'b0001, 4'b0011: alu_r = alu_a - alu_b;
         4'b0100: alu_r = alu_a & alu_b;
         4'b0101: alu_r = alu_a | alu_b;
         4'b0110: alu_r = alu_a ^ alu_b;
         4'b0111: alu_r = ~(alu_a | alu_b);
         4'b1000, 4'b1001: alu_r = {alu_b[15:0], 16'h0};
         4'b1011: alu_r = {31'b0, $signed(alu_a) < $signed(alu_b)};
         4'b1010: alu_r = {31'b0, alu_a < alu_b};
         4'b1100: alu_r = 32'($signed(alu_b) >>> alu_a[4:0]);
         4'b1101: alu_r = alu_b >> alu_a[4:0];
         default: alu_r = alu_b << alu_a[4:0];
      endcase
      if (aluc == 4'b0010) alu_overflow = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
      if (aluc == 4'b0011) alu_overflow = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
      alu_zero = (alu_r == 32'h0);
   end

   // kind: 0 write-back, 1 overflow trap, 2 illegal, 3 branch
   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] val;
      logic [3:0]  aluc;
      logic [31:0] a;
      logic [31:0] b;
      logic        taken;
   } exp_t;

   function automatic logic add_ovf(input logic [31:0] x, input logic [31:0] y, input logic [31:0] s);
      return (x[31] == y[31]) && (s[31] != x[31]);
   endfunction

   // Instruction-level semantics
   function automatic exp_t exp_of(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                   input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
      exp_t e;
      logic [31:0] se, ze;
      se = {{16{imm[15]}}, imm};
      ze = {16'h0, imm};
      e = '0;
      e.kind = 2'd0; e.a = rs; e.b = rt;
      case (op)
         6'h00: case (fn)
            6'h20: begin e.aluc = 4'h2; e.val = rs + rt; if (add_ovf(rs, rt, e.val)) e.kind = 2'd1; end
            6'h21: begin e.aluc = 4'h0; e.val = rs + rt; end
            6'h22: begin e.aluc = 4'h3; e.val = rs - rt; if (add_ovf(rs, ~rt, e.val) && (rs[31] != rt[31])) e.kind = 2'd1; end
            6'h23: begin e.aluc = 4'h1; e.val = rs - rt; end
            6'h24: begin e.aluc = 4'h4; e.val = rs & rt; end
            6'h25: begin e.aluc = 4'h5; e.val = rs | rt; end
            6'h26: begin e.aluc = 4'h6; e.val = rs ^ rt; end
            6'h27: begin e.aluc = 4'h7; e.val = ~(rs | rt); end
            6'h2A: begin e.aluc = 4'hB; e.val = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
            6'h2B: begin e.aluc = 4'hA; e.val = (rs < rt) ? 32'd1 : 32'd0; end
            6'h00: begin e.aluc = 4'hE; e.a = 32'(sh); e.val = rt << sh; end
            6'h02: begin e.aluc = 4'hD; e.a = 32'(sh); e.val = rt >> sh; end
            6'h03: begin e.aluc = 4'hC; e.a = 32'(sh); e.val = 32'($signed(rt) >>> sh); end
            6'h04: begin e.aluc = 4'hE; e.a = 32'(rs[4:0]); e.val = rt << rs[4:0]; end
            6'h06: begin e.aluc = 4'hD; e.a = 32'(rs[4:0]); e.val = rt >> rs[4:0]; end
            6'h07: begin e.aluc = 4'hC; e.a = 32'(rs[4:0]); e.val = 32'($signed(rt) >>> rs[4:0]); end
            default: e.kind = 2'd2;
         endcase
         6'h08: begin e.aluc = 4'h2; e.b = se; e.val = rs + se; if (add_ovf(rs, se, e.val)) e.kind = 2'd1; end
         6'h09: begin e.aluc = 4'h0; e.b = se; e.val = rs + se; end
         6'h0A: begin e.aluc = 4'hB; e.b = se; e.val = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0; end
         6'h0B: begin e.aluc = 4'hA; e.b = se; e.val = (rs < se) ? 32'd1 : 32'd0; end
         6'h0C: begin e.aluc = 4'h4; e.b = ze; e.val = rs & ze; end
         6'h0D: begin e.aluc = 4'h5; e.b = ze; e.val = rs | ze; end
         6'h0E: begin e.aluc = 4'h6; e.b = ze; e.val = rs ^ ze; end
         6'h0F: begin e.aluc = 4'h8; e.b = ze; e.val = {imm, 16'h0}; end
`ifdef EXEC_BRANCH_CMP_EN
         6'h04: begin e.kind = 2'd3; e.aluc = 4'h1; e.taken = (rs == rt); end
         6'h05: begin e.kind = 2'd3; e.aluc = 4'h1; e.taken = (rs != rt); end
`endif
         default: e.kind = 2'd2;
      endcase
      if (e.kind == 2'd2) e.aluc = 4'h0;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h required=%h", nm, act, exp);
   endtask

   // Reference timeline: phase 0 idle, 1 decode, 2 exec, 3 done
   int          m_phase;
   logic [5:0]  m_op, m_fn;
   logic [4:0]  m_sh;
   logic [15:0] m_imm;
   logic [31:0] m_rs, m_rt, m_res;
   logic        m_zero;
   exp_t        m_e;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0; m_res <= '0; m_zero <= 1'b0; m_e <= '0;
      end else begin
         if ((m_phase == 0 || m_phase == 3) && start) begin
            m_phase <= 1;
            m_op <= opcode; m_fn <= funct; m_sh <= shamt; m_imm <= imm16;
            m_rs <= rs_val; m_rt <= rt_val;
         end else if (m_phase == 1) begin
            m_phase <= 2;
         end else if (m_phase == 2) begin
            exp_t e;
            e = exp_of(m_op, m_fn, m_sh, m_imm, m_rs, m_rt);
            m_e <= e;
            m_phase <= 3;
            if (e.kind == 2'd0) begin m_res <= e.val; m_zero <= (e.val == 32'h0); end
         end else begin
            m_phase <= 0;
         end
      end
   end

   // Cycle-by-cycle comparison against the reference
   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy", busy, (m_phase == 1 || m_phase == 2));
         chk("done", done, (m_phase == 3));
         chk("result", result, m_res);
         chk("zero_q", zero_q, m_zero);
         if (m_phase == 3) begin
            chk("wb_en", wb_en, (m_e.kind == 2'd0));
            chk("ovf_trap", ovf_trap, (m_e.kind == 2'd1));
            chk("illegal", illegal, (m_e.kind == 2'd2));
            chk("aluc", aluc, m_e.aluc);
            if (m_e.kind != 2'd2) begin
               chk("alu_a", alu_a, m_e.a);
               chk("alu_b", alu_b, m_e.b);
            end
`ifdef EXEC_BRANCH_CMP_EN
            chk("branch_taken", branch_taken, (m_e.kind == 2'd3) && m_e.taken);
`endif
         end else begin
            chk("idle_flags", {wb_en, ovf_trap, illegal}, 3'b000);
         end
      end
   end

   task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
      opcode = op; funct = fn; shamt = sh; imm16 = imm; rs_val = rs; rt_val = rt;
   endtask

   // One-cycle start pulse; returns just after the accepting edge
   task automatic do_op(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
      @(posedge clk); #2;
      set_in(op, fn, sh, imm, rs, rt);
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic wait_done(output int cycles);
      bit got;
      got = 1'b0; cycles = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         cycles++;
         if (done) got = 1'b1;
      end
      if (!got) chk("done_timeout", 32'd0, 32'd1);
   endtask

   function automatic logic [31:0] rv();
      case ($urandom_range(0, 5))
         0: return 32'h7FFFFFFF;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   task automatic rand_inputs();
      logic [5:0] fns [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 5) opcode = 6'h00;
      else if (sel < 9) opcode = 6'($urandom_range(8, 15));
      else opcode = 6'($urandom_range(0, 63));
      funct = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 15)];
      shamt = 5'($urandom);
      imm16 = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      rs_val = rv();
      rt_val = ($urandom_range(0, 3) == 0) ? rs_val : rv();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc;
      exp_t pin;
      rst_n = 1'b0; start = 1'b0;
      set_in(6'h00, 6'h00, 5'd0, 16'h0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_result", result, 32'h0);
      chk("rst_flags", {busy, done, zero_q, wb_en, ovf_trap, illegal}, 6'b0);
      chk("rst_aluc", aluc, 4'h0);
      chk("rst_alu_a", alu_a, 32'h0);

      // Model pins
      pin = exp_of(6'h00, 6'h03, 5'd4, 16'h0, 32'h0, 32'h80000000);
      chk("model_sra", pin.val, 32'hF8000000);
      pin = exp_of(6'h08, 6'h00, 5'd0, 16'hFFFF, 32'h80000000, 32'h0);
      chk("model_addi_ovf", 32'(pin.kind), 32'd1);

      // Abort mid-EXEC with asynchronous reset
      @(posedge clk); #2 rst_n = 1'b1;
      do_op(6'h00, 6'h21, 5'd0, 16'h0, 32'hFFFFFFFF, 32'h1);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("abort_done", done, 1'b0);
      chk("abort_busy", busy, 1'b0);
      @(posedge clk); #2 rst_n = 1'b1;
      @(negedge clk);
      chk("abort_no_done", done, 1'b0);

      // addu wrap to zero
      do_op(6'h00, 6'h21, 5'd0, 16'h0, 32'hFFFFFFFF, 32'h1);
      wait_done(cyc);
      chk("addu_latency", 32'(cyc), 32'd3);
      chk("addu_result", result, 32'h0);
      chk("addu_flags", {zero_q, wb_en, ovf_trap}, 3'b110);

      // Signed overflow keeps prior result
      do_op(6'h00, 6'h20, 5'd0, 16'h0, 32'h7FFFFFFF, 32'h1);
      wait_done(cyc);
      chk("add_ovf", {ovf_trap, wb_en}, 2'b10);
      chk("add_ovf_result", result, 32'h0);
      do_op(6'h08, 6'h00, 5'd0, 16'hFFFF, 32'h80000000, 32'h0);
      wait_done(cyc);
      chk("addi_ovf", {ovf_trap, wb_en}, 2'b10);

      // Shifts
      do_op(6'h00, 6'h03, 5'd4, 16'h0, 32'h0, 32'h80000000);
      wait_done(cyc);
      chk("sra_a", alu_a, 32'h4);
      chk("sra_result", result, 32'hF8000000);
      do_op(6'h00, 6'h06, 5'd0, 16'h0, 32'h24, 32'hF0);
      wait_done(cyc);
      chk("srlv_a", alu_a, 32'h4);
      chk("srlv_result", result, 32'h0F);

      // Immediates
      do_op(6'h0D, 6'h00, 5'd0, 16'h8001, 32'h12340000, 32'h0);
      wait_done(cyc);
      chk("ori_b", alu_b, 32'h00008001);
      chk("ori_result", result, 32'h12348001);
      do_op(6'h0A, 6'h00, 5'd0, 16'hFFFF, 32'h0, 32'h0);
      wait_done(cyc);
      chk("slti_b", alu_b, 32'hFFFFFFFF);
      chk("slti_result", result, 32'h0);
      do_op(6'h0F, 6'h00, 5'd0, 16'hABCD, 32'h0, 32'h0);
      wait_done(cyc);
      chk("lui_result", result, 32'hABCD0000);

      // Back-to-back with start held high: sltu then nor
      @(posedge clk); #2;
      set_in(6'h00, 6'h2B, 5'd0, 16'h0, 32'd3, 32'd5);
      start = 1'b1;
      @(posedge clk); #2;
      set_in(6'h00, 6'h27, 5'd0, 16'h0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("b2b_sltu_done", done, 1'b1);
      chk("b2b_sltu_result", result, 32'h1);
      chk("b2b_sltu_no_ovf", ovf_trap, 1'b0);
      @(posedge clk); #2 start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("b2b_nor_done", done, 1'b1);
      chk("b2b_nor_result", result, 32'hFFFFFFFF);

      // Start in DECODE ignored, inputs not re-latched
      @(posedge clk); #2;
      set_in(6'h00, 6'h26, 5'd0, 16'h0, 32'hF0, 32'h0F);
      start = 1'b1;
      @(posedge clk); #2;
      set_in(6'h00, 6'h24, 5'd0, 16'h0, 32'h0, 32'h0);
      @(posedge clk); #2 start = 1'b0;
      wait_done(cyc);
      chk("ignore_result", result, 32'hFF);
      @(negedge clk);
      chk("ignore_no_redo", done, 1'b0);

      // Illegal opcode
      do_op(6'h3F, 6'h00, 5'd0, 16'h0, 32'h1, 32'h2);
      wait_done(cyc);
      chk("illegal_flags", {illegal, wb_en, ovf_trap}, 3'b100);
      chk("illegal_aluc", aluc, 4'h0);
      chk("illegal_result", result, 32'hFF);

`ifdef EXEC_BRANCH_CMP_EN
      do_op(6'h04, 6'h00, 5'd0, 16'h0, 32'd7, 32'd7);
      wait_done(cyc);
      chk("beq_taken", {branch_taken, wb_en}, 2'b10);
      do_op(6'h05, 6'h00, 5'd0, 16'h0, 32'd7, 32'd7);
      wait_done(cyc);
      chk("bne_taken", {branch_taken, wb_en}, 2'b00);
`else
      do_op(6'h04, 6'h00, 5'd0, 16'h0, 32'd7, 32'd7);
      wait_done(cyc);
      chk("beq_illegal", illegal, 1'b1);
`endif

      // Randomized traffic, inputs and start toggling every cycle
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #2;
         rand_inputs();
         start = ($urandom_range(0, 2) != 0);
      end
      @(posedge clk); #2 start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
